instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage feeding the 16K×16 instruction memory (IM).
- Owns the 14-bit program counter and drives IM address and read-enable.
- Registers the returned instruction and its PC+1 into the IF/ID pipeline register for the decode stage.
- Handles decode stalls, control-flow redirects from later stages, and a sticky halt on the HLT opcode.

## Interface
Parameters:
- ADDR_W, 14, IM address / PC width
- INSTR_W, 16, instruction width
- HLT_OP, 4'hF, opcode field value (instr[15:12]) that halts fetch

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall_IF_ID  in  1  decode cannot accept; hold PC and IF/ID
- flow_change  in  1  redirect from execute (taken branch/jump/return)
- dst  in  ADDR_W  redirect target PC, valid with flow_change
- instr  in  INSTR_W  IM read data (IM flops it on negedge of clk)
- im_addr  out  ADDR_W  IM address, equals PC register
- im_rd_en  out  1  IM read enable
- instr_ID  out  INSTR_W  IF/ID registered instruction
- pc_ID  out  ADDR_W  IF/ID registered PC+1 of instr_ID
- valid_ID  out  1  instr_ID is a real, non-squashed instruction
- halted  out  1  fetch frozen by HLT

## Operation
- One fetch per cycle when not stalled, halted or in reset.
- PC update priority: rst > flow_change > halted > stall_IF_ID > increment.
  - rst: PC ← 0.
  - flow_change: PC ← dst; IF/ID valid_ID ← 0 (wrong-path instruction squashed); halted ← 0.
  - halted: PC holds; IF/ID holds.
  - stall_IF_ID: PC, instr_ID, pc_ID and valid_ID hold.
  - else: PC ← PC+1 mod 2^14 (16383 wraps to 0); instr_ID ← instr, pc_ID ← PC+1, valid_ID ← 1.
- im_rd_en = !rst & !halted & !stall_IF_ID & !flow_change. Deasserting it during a stall makes IM hold its output, so no instruction is lost.
- Halt: halted sets when an increment cycle captures an instruction with instr[15:12]==HLT_OP. The HLT itself is presented with valid_ID=1. It stays set until rst or flow_change; flow_change clears it, because HLT may be wrong-path.
- stall_IF_ID and flow_change together: flow_change wins; the stall is ignored for that cycle.

## Timing
- Reset values: PC=0, im_addr=0, im_rd_en=0, instr_ID=16'h0000, pc_ID=0, valid_ID=0, halted=0.
- Fetch latency is 1 cycle:
  - im_addr is presented in cycle N.
  - IM data arrives mid-cycle (negedge).
  - instr_ID/valid_ID update at the posedge ending cycle N.
- First fetch after reset deasserts: addr 0 in cycle 1; instr_ID valid at the end of cycle 1.
- Redirect penalty is 1 bubble: valid_ID=0 for the cycle after flow_change; target instruction valid one cycle later.
- rst asserted mid-operation: all state returns to reset values at that posedge, regardless of stall, halt or redirect.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each increment-cycle capture.
  - stall_cnt increments on each cycle with stall_IF_ID=1 and neither halted nor flow_change.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package: ADDR_W/INSTR_W defaults, HLT opcode constant, opcode field bit positions (15:12). The decode stage uses the same package.
- Sub-module fetch_perf_cnt holds both saturating counters; it is instantiated only under FETCH_PERF_CNT_EN.
- The PC/IF-ID logic stays flat in instr_fetch.

## Test plan
- Reset release, IM loaded with instr[k]=16'h1000+k, no stalls:
  - valid_ID=1 from end of cycle 1.
  - instr_ID sequence 16'h1000, 16'h1001, …
  - pc_ID = 1, 2, …
- stall_IF_ID high for 3 cycles at PC=5:
  - im_rd_en=0 and instr_ID=16'h1004 for those 3 cycles.
  - After release, 16'h1005 follows with no skip or duplicate.
- flow_change with dst=14'h0100 at PC=8:
  - Next cycle valid_ID=0.
  - Following cycle instr_ID=instr[0x100], pc_ID=0x101.
  - Repeat with stall_IF_ID also high: same result.
- HLT (16'hF000) at address 3:
  - valid_ID=1 with instr_ID=16'hF000, then halted=1.
  - PC frozen at 4, im_rd_en=0.
  - A later flow_change dst=0 clears halted and fetch resumes from 0.
- Wrap-around: dst=14'h3FFF, then free run: instr[0x3FFF] then instr[0x0000]; pc_ID 0x0000 then 0x0001.
- With FETCH_PERF_CNT_EN: 10 fetches and 4 stall cycles give fetch_cnt=10, stall_cnt=4; rst mid-run zeroes both.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch/decode constants and types
// Holds the default widths, the HLT opcode and the opcode field position used by fetch and decode.
package instr_fetch_pkg;

  localparam int         ADDR_W_DEF  = 14;
  localparam int         INSTR_W_DEF = 16;
  localparam int         OP_MSB      = 15;
  localparam int         OP_LSB      = 12;
  localparam logic [3:0] HLT_OPCODE  = 4'hF;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bus: decode/execute controls, IM port and IF/ID register
// master is the fetch stage; slave is the surrounding pipeline and instruction memory.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();

  logic               stall_IF_ID;
  logic               flow_change;
  logic [ADDR_W-1:0]  dst;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] instr_ID;
  logic [ADDR_W-1:0]  pc_ID;
  logic               valid_ID;
  logic               halted;

  modport master (
    input  stall_IF_ID, flow_change, dst, instr,
    output im_addr, im_rd_en, instr_ID, pc_ID, valid_ID, halted
  );

  modport slave (
    output stall_IF_ID, flow_change, dst, instr,
    input  im_addr, im_rd_en, instr_ID, pc_ID, valid_ID, halted
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating fetch and stall counters (FETCH_PERF_CNT_EN only)
// Counts capture cycles and genuine decode-stall cycles; both stick at all-ones.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch,
  input  logic        i_stall,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule
`endif

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, IM request, IF/ID register, sticky HLT
// FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt outputs backed by fetch_perf_cnt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter int         INSTR_W = INSTR_W_DEF,
  parameter logic [3:0] HLT_OP  = HLT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  instr_fetch_if.master bus
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [INSTR_W-1:0] r_instr_id;
  logic [ADDR_W-1:0]  r_pc_id;
  logic               r_valid_id;
  logic               w_halted;
  logic               w_capture;

  assign w_halted  = (r_state == S_HALT);
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_capture = !bus.flow_change && !w_halted && !bus.stall_IF_ID;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A redirect always releases halt: the HLT that caused it may have been wrong-path.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (w_capture && (bus.instr[OP_MSB:OP_LSB] == HLT_OP)) w_state_next = S_HALT;
      S_HALT:  if (bus.flow_change) w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_instr_id <= '0;
      r_pc_id    <= '0;
      r_valid_id <= 1'b0;
    end else if (bus.flow_change) begin
      r_pc       <= bus.dst;
      r_valid_id <= 1'b0;
    end else if (w_capture) begin
      r_pc       <= w_pc_inc;
      r_instr_id <= bus.instr;
      r_pc_id    <= w_pc_inc;
      r_valid_id <= 1'b1;
    end
  end

  // Dropping the read enable on stall makes the IM hold its data, so nothing is refetched.
  assign bus.im_addr  = r_pc;
  assign bus.im_rd_en = !rst && !w_halted && !bus.stall_IF_ID && !bus.flow_change;
  assign bus.instr_ID = r_instr_id;
  assign bus.pc_ID    = r_pc_id;
  assign bus.valid_ID = r_valid_id;
  assign bus.halted   = w_halted;

`ifdef FETCH_PERF_CNT_EN
  logic w_stall_cycle;
  assign w_stall_cycle = bus.stall_IF_ID && !w_halted && !bus.flow_change;

  fetch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_fetch     (w_capture),
    .i_stall     (w_stall_cycle),
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with an IM model and reference model
// Honours FETCH_PERF_CNT_EN for the counter outputs.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  logic [15:0] mem [0:16383];

  // Instruction memory: registers read data on the falling edge when enabled.
  always @(negedge clk) begin
    if (bus.im_rd_en) bus.instr <= mem[bus.im_addr];
  end

  int n_total = 0;
  int n_pass  = 0;

  int          m_pc;
  bit          m_halted;
  bit          m_valid;
  logic [15:0] m_instr;
  int          m_pcid;
  longint      m_fcnt;
  longint      m_scnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_halted = 0; m_valid = 0; m_instr = 16'h0000; m_pcid = 0;
    m_fcnt = 0; m_scnt = 0;
  endtask

  task automatic check_state();
    chk("instr_ID", bus.instr_ID, m_instr);
    chk("pc_ID",    bus.pc_ID,    m_pcid);
    chk("valid_ID", bus.valid_ID, m_valid);
    chk("halted",   bus.halted,   m_halted);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fcnt[31:0]);
    chk("stall_cnt", stall_cnt, m_scnt[31:0]);
`endif
  endtask

  // One clock: drive inputs, check IM request, advance model, check IF/ID after the edge.
  task automatic cycle(input bit r, input bit s, input bit fc, input int d);
    logic [15:0] word;
    rst = r; bus.stall_IF_ID = s; bus.flow_change = fc; bus.dst = 14'(d);
    #1;
    chk("im_rd_en", bus.im_rd_en, (!r && !m_halted && !s && !fc));
    chk("im_addr",  bus.im_addr,  m_pc);
    if (r) begin
      model_reset();
    end else begin
      if (s && !m_halted && !fc && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (fc) begin
        m_pc = d % 16384; m_valid = 0; m_halted = 0;
      end else if (!m_halted && !s) begin
        word    = mem[m_pc];
        m_instr = word;
        m_pcid  = (m_pc + 1) % 16384;
        m_valid = 1;
        if (word[15:12] == 4'hF) m_halted = 1;
        m_pc = m_pcid;
        if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 16'(16'h1000 + k);
    rst = 1'b1; bus.stall_IF_ID = 1'b0; bus.flow_change = 1'b0; bus.dst = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_state();
    chk("rst_im_addr",  bus.im_addr,  0);
    chk("rst_im_rd_en", bus.im_rd_en, 0);
    chk("rst_instr_ID", bus.instr_ID, 16'h0000);

    // Free run from reset release.
    cycle(0, 0, 0, 0);
    chk("first_instr", bus.instr_ID, 16'h1000);
    chk("first_pc_ID", bus.pc_ID,    1);
    chk("first_valid", bus.valid_ID, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Three-cycle stall at PC=5.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      chk("stall_hold", bus.instr_ID, 16'h1004);
    end
    cycle(0, 0, 0, 0);
    chk("stall_release", bus.instr_ID, 16'h1005);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Redirect at PC=8, then again with a simultaneous stall.
    chk("pc_before_redirect", bus.im_addr, 8);
    cycle(0, 0, 1, 'h100);
    chk("redirect_bubble", bus.valid_ID, 0);
    cycle(0, 0, 0, 0);
    chk("redirect_instr", bus.instr_ID, 16'h1100);
    chk("redirect_pc_ID", bus.pc_ID, 'h101);
    cycle(0, 1, 1, 'h100);
    chk("redirect_stall_bubble", bus.valid_ID, 0);
    cycle(0, 0, 0, 0);
    chk("redirect_stall_instr", bus.instr_ID, 16'h1100);
    chk("redirect_stall_pc_ID", bus.pc_ID, 'h101);

    // HLT at address 3.
    mem[3] = 16'hF000;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("hlt_instr",  bus.instr_ID, 16'hF000);
    chk("hlt_valid",  bus.valid_ID, 1);
    chk("hlt_halted", bus.halted,   1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("hlt_pc_frozen", bus.im_addr, 4);
    cycle(0, 0, 1, 0);
    chk("hlt_cleared", bus.halted, 0);
    cycle(0, 0, 0, 0);
    chk("hlt_resume", bus.instr_ID, 16'h1000);
    mem[3] = 16'h1003;

    // PC wrap-around.
    cycle(0, 0, 1, 'h3FFF);
    cycle(0, 0, 0, 0);
    chk("wrap_instr", bus.instr_ID, 16'h4FFF);
    chk("wrap_pc_ID", bus.pc_ID, 0);
    cycle(0, 0, 0, 0);
    chk("wrap_next_instr", bus.instr_ID, 16'h1000);
    chk("wrap_next_pc_ID", bus.pc_ID, 1);

`ifdef FETCH_PERF_CNT_EN
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(0, (i % 3 == 1) && (i < 12), 0, 0);
    chk("perf_fetch_10", fetch_cnt, 10);
    chk("perf_stall_4",  stall_cnt, 4);
    cycle(1, 0, 0, 0);
    chk("perf_rst_fetch", fetch_cnt, 0);
    chk("perf_rst_stall", stall_cnt, 0);
`endif

    // Randomized traffic over random memory contents (opcode F halts naturally).
    for (int k = 0; k < 16384; k++) mem[k] = 16'($urandom);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int d;
      if ($urandom_range(0, 3) == 0) d = 16383 - $urandom_range(0, 2);
      else d = $urandom_range(0, 16383);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
